mod_share_arb: RTL and testbench



---
 rtl/mod_share_arb_pkg.sv | 19 +
 rtl/mod_share_arb_mod.sv | 18 +
 rtl/mod_share_arb_rr_pick.sv | 33 +++
 rtl/mod_share_arb.sv | 190 +++++++++++++++++++
 tb/tb_mod_share_arb.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mod_share_arb_pkg.sv
// Shared constants for the MOD arbiter slice: FSM encodings, statistics
// counter width and a saturating increment helper.
package mod_share_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int STATS_W = 16;

  typedef logic [STATS_W-1:0] stats_t;

  // Counters stick at all-ones rather than wrapping back to zero.
  function automatic stats_t sat_inc(input stats_t v);
    return (v == '1) ? v : v + STATS_W'(1);
  endfunction

endpackage

// File: rtl/mod_share_arb_mod.sv
// Remainder datapath: unsigned a % b. The owning arbiter treats this as
// a multicycle path and never samples it while the divisor is zero; the zero
// guard only keeps the output defined in that case.
module mod_unit #(
  parameter int DATAWIDTH = 8
) (
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  output logic [DATAWIDTH-1:0] rem
);

  // Pure combinational remainder.
  always_comb begin
    rem = a;
    if (b != '0) rem = a % b;
  end

endmodule

// File: rtl/mod_share_arb_rr_pick.sv
// Round-robin picker: returns the first asserted request at or above ptr,
// wrapping around past NREQ-1 back to 0.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   grant,
  output logic            any
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  // Scan from ptr upward with wrap; the first hit wins.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
      idx = sum[PW-1:0];
      if (!any && req[idx]) begin
        grant = idx;
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mod_share_arb.sv
// Time-shares one MOD unit among NREQ requesters with round-robin fairness.
// Operands are captured on accept, the divider gets LAT settle cycles, and
// the remainder returns with a one-hot valid pulse. Zero divisors bypass the
// divider entirely. Optional statistics: define MOD_ARB_STATS_EN to add the
// ops_cnt/divz_cnt outputs.
module mod_share_arb
  import mod_share_arb_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int NREQ      = 4,
  parameter int LAT       = 2
) (
  input  logic                      Clk,
  input  logic                      Rst_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*DATAWIDTH-1:0] req_a,
  input  logic [NREQ*DATAWIDTH-1:0] req_b,
  output logic [NREQ-1:0]           req_ready,
  output logic [NREQ-1:0]           rsp_valid,
  output logic [DATAWIDTH-1:0]      rsp_rem,
  output logic                      rsp_divz,
  output logic                      busy
`ifdef MOD_ARB_STATS_EN
  ,
  output logic [STATS_W-1:0]        ops_cnt,
  output logic [STATS_W-1:0]        divz_cnt
`endif
);

  localparam int PW    = $clog2(NREQ);
  localparam int CNT_W = $clog2(LAT + 1);

  logic [1:0]           state_q, state_d;
  logic [PW-1:0]        grant_q, grant_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [DATAWIDTH-1:0] op_a_q, op_a_d;
  logic [DATAWIDTH-1:0] op_b_q, op_b_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [DATAWIDTH-1:0] rem_q, rem_d;
  logic                 divz_q, divz_d;

  logic [PW-1:0]        pick_grant;
  logic                 pick_any;
  logic [DATAWIDTH-1:0] mod_rem;
  logic [DATAWIDTH-1:0] sel_a, sel_b;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .any   (pick_any)
  );

  // The divider only ever sees the captured operands, never live inputs.
  mod_unit #(
    .DATAWIDTH (DATAWIDTH)
  ) u_mod (
    .a   (op_a_q),
    .b   (op_b_q),
    .rem (mod_rem)
  );

  // Pick the granted requester's operand slices.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q == PW'(i)) begin
        sel_a = req_a[i*DATAWIDTH +: DATAWIDTH];
        sel_b = req_b[i*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

  // FSM next-state: arbitrate, capture, let the divider settle, respond.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    count_d = count_q;
    rem_d   = rem_q;
    divz_d  = divz_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_grant;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        op_a_d = sel_a;
        op_b_d = sel_b;
        if (sel_b == '0) begin
          rem_d   = sel_a;
          divz_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          count_d = CNT_W'(1);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (count_q == CNT_W'(LAT)) begin
          rem_d   = mod_rem;
          divz_d  = 1'b0;
          count_d = '0;
          state_d = ST_DONE;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        ptr_d   = (grant_q == PW'(NREQ - 1)) ? '0 : grant_q + PW'(1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset abandons any operation in flight.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      count_q <= '0;
      rem_q   <= '0;
      divz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      divz_q  <= divz_d;
    end
  end

  // Handshake strobes are decoded from state so they are glitch-free.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (state_q == ST_LOAD) req_ready[grant_q] = 1'b1;
    if (state_q == ST_DONE) rsp_valid[grant_q] = 1'b1;
    busy     = (state_q != ST_IDLE);
    rsp_rem  = rem_q;
    rsp_divz = divz_q;
  end

`ifdef MOD_ARB_STATS_EN
  logic [STATS_W-1:0] ops_cnt_q, ops_cnt_d;
  logic [STATS_W-1:0] divz_cnt_q, divz_cnt_d;

  // Count completed operations and the zero-divisor subset.
  always_comb begin
    ops_cnt_d  = ops_cnt_q;
    divz_cnt_d = divz_cnt_q;
    if (state_q == ST_DONE) begin
      ops_cnt_d = sat_inc(ops_cnt_q);
      if (divz_q) divz_cnt_d = sat_inc(divz_cnt_q);
    end
  end

  // Statistics registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ops_cnt_q  <= '0;
      divz_cnt_q <= '0;
    end else begin
      ops_cnt_q  <= ops_cnt_d;
      divz_cnt_q <= divz_cnt_d;
    end
  end

  assign ops_cnt  = ops_cnt_q;
  assign divz_cnt = divz_cnt_q;
`else
  // No statistics hardware in this build.
`endif

endmodule

// File: tb/tb_mod_share_arb.sv
// Scoreboard bench for mod_share_arb (DATAWIDTH=8, NREQ=4, LAT=2).
// Stimulus pushes hand-computed responses; a negedge monitor pops and checks.
module tb_mod_share_arb;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int LT = 2;

  logic             Clk = 1'b0;
  logic             Rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_a;
  logic [NR*DW-1:0] req_b;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_rem;
  logic             rsp_divz;
  logic             busy;
`ifdef MOD_ARB_STATS_EN
  logic [15:0]      ops_cnt;
  logic [15:0]      divz_cnt;
`endif

  mod_share_arb #(
    .DATAWIDTH (DW),
    .NREQ      (NR),
    .LAT       (LT)
  ) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rem   (rsp_rem),
    .rsp_divz  (rsp_divz),
    .busy      (busy)
`ifdef MOD_ARB_STATS_EN
    ,
    .ops_cnt   (ops_cnt),
    .divz_cnt  (divz_cnt)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int idx;
    int rem;
    int divz;
    int at_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   exp_ready[NR];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Free-running cycle index, read on the falling edge.
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int required);
    total++;
    if (actual != required) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  // Monitor: every response pulse must match the oldest expectation.
  always @(negedge Clk) begin
    if (Rst_n && rsp_valid != '0) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_rsp", int'(rsp_valid), 0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("rsp_owner", int'(rsp_valid), 1 << mon_e.idx);
        checkOutput("rsp_rem", int'(rsp_rem), mon_e.rem);
        checkOutput("rsp_divz", int'(rsp_divz), mon_e.divz);
        checkOutput("rsp_cycle", cyc, mon_e.at_cyc);
      end
    end
  end

  // Raise one request and record when its accept and response are due.
  task automatic applyStimulus(input int idx, input int a, input int b,
                               input int ready_off, input int rsp_off,
                               input bit expect_rsp, input int exp_rem, input int exp_divz);
    req_a[idx*DW +: DW] = DW'(a);
    req_b[idx*DW +: DW] = DW'(b);
    req_valid[idx]      = 1'b1;
    exp_ready[idx]      = cyc + ready_off;
    if (expect_rsp) sb.push_back('{idx, exp_rem, exp_divz, cyc + rsp_off});
  endtask

  // Hold requests until accepted, dropping each one the cycle after its accept.
  task automatic waitAccepted(input logic [NR-1:0] mask);
    logic [NR-1:0] pending;
    logic [NR-1:0] acked;
    int guard;
    pending = mask;
    acked   = '0;
    guard   = 0;
    while (pending != '0 && guard < 100) begin
      @(negedge Clk);
      guard++;
      req_valid = req_valid & ~acked;
      acked     = req_ready & pending;
      if (req_ready != '0) checkOutput("ready_onehot", int'($onehot(req_ready)), 1);
      for (int i = 0; i < NR; i++)
        if (acked[i]) checkOutput("ready_cycle", cyc, exp_ready[i]);
      pending = pending & ~acked;
    end
    if (pending != '0) begin
      checkOutput("ready_timeout", int'(pending), 0);
      req_valid = req_valid & ~pending;
    end
    @(negedge Clk);
    req_valid = req_valid & ~acked;
  endtask

  // Wait for all expected responses and the arbiter to return to idle.
  task automatic drain();
    int guard;
    guard = 0;
    while ((sb.size() != 0 || busy) && guard < 100) begin
      @(negedge Clk);
      guard++;
    end
    if (guard >= 100) begin
      checkOutput("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin
    Rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    repeat (2) @(negedge Clk);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_req_ready", int'(req_ready), 0);
    checkOutput("reset_rsp_valid", int'(rsp_valid), 0);
    checkOutput("reset_rsp_rem", int'(rsp_rem), 0);
    checkOutput("reset_rsp_divz", int'(rsp_divz), 0);
    Rst_n = 1'b1;
    @(negedge Clk);

    // All four at once from ptr 0: served 0,1,2,3 five cycles apart.
    applyStimulus(0, 100,  7,  1,  4, 1,  2, 0);
    applyStimulus(1,  45,  8,  6,  9, 1,  5, 0);
    applyStimulus(2,  99, 10, 11, 14, 1,  9, 0);
    applyStimulus(3,  77, 13, 16, 19, 1, 12, 0);
    waitAccepted(4'b1111);
    drain();

    // Pointer is back at 0: requester 1 then 3.
    applyStimulus(1, 23, 4, 1, 4, 1, 3, 0);
    applyStimulus(3, 65, 6, 6, 9, 1, 5, 0);
    waitAccepted(4'b1010);
    drain();

    // Basic single operation.
    applyStimulus(0, 17, 5, 1, 4, 1, 2, 0);
    waitAccepted(4'b0001);
    drain();

    // Operand edge cases.
    applyStimulus(0, 255, 1, 1, 4, 1, 0, 0);
    waitAccepted(4'b0001);
    drain();
    applyStimulus(0, 3, 255, 1, 4, 1, 3, 0);
    waitAccepted(4'b0001);
    drain();
    applyStimulus(0, 0, 7, 1, 4, 1, 0, 0);
    waitAccepted(4'b0001);
    drain();
    applyStimulus(0, 255, 255, 1, 4, 1, 0, 0);
    waitAccepted(4'b0001);
    drain();

    // Divide by zero short-circuits to DONE two cycles after the request.
    applyStimulus(2, 9, 0, 1, 2, 1, 9, 1);
    waitAccepted(4'b0100);
    drain();

    // Reset during WAIT: everything clears at once and no response appears.
    applyStimulus(1, 30, 4, 1, 0, 0, 0, 0);
    waitAccepted(4'b0010);
    Rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_rsp_valid", int'(rsp_valid), 0);
    checkOutput("abort_rsp_rem", int'(rsp_rem), 0);
    checkOutput("abort_rsp_divz", int'(rsp_divz), 0);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    repeat (6) @(negedge Clk);
    checkOutput("abort_idle_after_release", int'(busy), 0);

    // Pointer restarted at 0, so requester 0 beats requester 3.
    applyStimulus(0, 50, 7, 1, 4, 1, 1, 0);
    applyStimulus(3, 40, 6, 6, 9, 1, 4, 0);
    waitAccepted(4'b1001);
    drain();

`ifdef MOD_ARB_STATS_EN
    Rst_n = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    checkOutput("stats_reset_ops", int'(ops_cnt), 0);
    applyStimulus(0, 10, 3, 1, 4, 1, 1, 0);
    waitAccepted(4'b0001);
    drain();
    applyStimulus(1, 8, 0, 1, 2, 1, 8, 1);
    waitAccepted(4'b0010);
    drain();
    applyStimulus(2, 20, 6, 1, 4, 1, 2, 0);
    waitAccepted(4'b0100);
    drain();
    checkOutput("stats_ops_cnt", int'(ops_cnt), 3);
    checkOutput("stats_divz_cnt", int'(divz_cnt), 1);
    force dut.ops_cnt_q  = 16'hFFFF;
    force dut.divz_cnt_q = 16'hFFFF;
    @(negedge Clk);
    release dut.ops_cnt_q;
    release dut.divz_cnt_q;
    applyStimulus(3, 5, 0, 1, 2, 1, 5, 1);
    waitAccepted(4'b1000);
    drain();
    checkOutput("stats_ops_sat", int'(ops_cnt), 16'hFFFF);
    checkOutput("stats_divz_sat", int'(divz_cnt), 16'hFFFF);
`endif

    repeat (3) @(negedge Clk);
    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
